// File: rtl/linear_layer_start_srl_fifo_if.sv
// Handshake bundle for the start-token FIFO: producer write side and
// consumer read side, ap_fifo style. The FIFO block uses the slave view.
interface linear_layer_start_srl_fifo_if #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1
);
   logic                  if_write_ce;
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_read_ce;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;
   logic [ADDR_WIDTH:0]   if_num_data_valid;

   modport slave (
      input  if_write_ce, if_write, if_din, if_read_ce, if_read,
      output if_full_n, if_dout, if_empty_n, if_num_data_valid
   );

   modport master (
      output if_write_ce, if_write, if_din, if_read_ce, if_read,
      input  if_full_n, if_dout, if_empty_n, if_num_data_valid
   );
endinterface

// File: rtl/linear_layer_start_srl_fifo.sv
// Show-ahead SRL-style FIFO for start tokens between dataflow processes.
// Writes shift the whole array up and land at entry[0]; the head is read
// at a pointer that tracks occupancy-1, so the oldest token sits at the
// highest valid index. Flags are registered from next-state occupancy.
module linear_layer_start_srl_fifo #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic clk,
   input  logic reset_n,
   linear_layer_start_srl_fifo_if.slave fifo
);

   typedef logic [ADDR_WIDTH:0] cnt_t;

   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   // One extra bit so -1 (empty) is distinct from DEPTH-1 (full).
   cnt_t                  ptr_q, ptr_d;
   cnt_t                  num_q, num_d;
   logic                  empty_n_q, full_n_q;
   logic                  push, pop;
   logic [ADDR_WIDTH-1:0] rd_idx;

   assign push   = fifo.if_write & fifo.if_write_ce & full_n_q;
   assign pop    = fifo.if_read  & fifo.if_read_ce  & empty_n_q;
   assign rd_idx = ptr_q[ADDR_WIDTH-1:0];

   // Shift storage on every accepted write; no reset so it maps onto SRLs.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = DEPTH-1; i > 0; i--) mem[i] <= mem[i-1];
         mem[0] <= fifo.if_din;
      end
   end

   // Head-of-queue select; index stays inside the array even when ptr is -1.
   always_comb begin
      fifo.if_dout = mem[0];
      for (int i = 0; i < DEPTH; i++)
         if (rd_idx == ADDR_WIDTH'(i)) fifo.if_dout = mem[i];
   end

   // Next pointer/occupancy; push+pop together leaves both unchanged.
   always_comb begin
      ptr_d = ptr_q;
      num_d = num_q;
      if (push && !pop) begin
         ptr_d = ptr_q + cnt_t'(1);
         num_d = num_q + cnt_t'(1);
      end else if (pop && !push) begin
         ptr_d = ptr_q - cnt_t'(1);
         num_d = num_q - cnt_t'(1);
      end
   end

   // Pointer, occupancy and flags; reset drops every queued token at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q     <= '1;
         num_q     <= '0;
         empty_n_q <= 1'b0;
         full_n_q  <= 1'b1;
      end else begin
         ptr_q     <= ptr_d;
         num_q     <= num_d;
         empty_n_q <= (num_d != '0);
         full_n_q  <= (num_d != DEPTH_C);
      end
   end

   assign fifo.if_empty_n        = empty_n_q;
   assign fifo.if_full_n         = full_n_q;
   assign fifo.if_num_data_valid = num_q;

   a_num_range : assert property (@(posedge clk) disable iff (!reset_n)
      num_q <= DEPTH_C);
   a_ptr_track : assert property (@(posedge clk) disable iff (!reset_n)
      ptr_q == num_q - cnt_t'(1));

endmodule

// File: tb/tb_linear_layer_start_srl_fifo.sv
// Directed bench: a DEPTH=2 instance for fill/drain, overflow/underflow,
// simultaneous push/pop and ce gating; a DEPTH=4 instance for mid-stream reset.
module tb_linear_layer_start_srl_fifo;

   logic clk = 1'b0;
   logic rst_a_n, rst_b_n;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   linear_layer_start_srl_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) fa ();
   linear_layer_start_srl_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) fb ();

   linear_layer_start_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u_a (
      .clk(clk), .reset_n(rst_a_n), .fifo(fa.slave));
   linear_layer_start_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_b (
      .clk(clk), .reset_n(rst_b_n), .fifo(fb.slave));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One cycle on instance A; inputs held over the edge then released.
   task automatic op_a(input logic w, input logic [7:0] d, input logic r,
                       input logic wce = 1'b1, input logic rce = 1'b1);
      fa.if_write = w; fa.if_din = d; fa.if_read = r;
      fa.if_write_ce = wce; fa.if_read_ce = rce;
      @(posedge clk); #1;
      fa.if_write = 1'b0; fa.if_read = 1'b0;
   endtask

   task automatic op_b(input logic w, input logic [7:0] d, input logic r);
      fb.if_write = w; fb.if_din = d; fb.if_read = r;
      fb.if_write_ce = 1'b1; fb.if_read_ce = 1'b1;
      @(posedge clk); #1;
      fb.if_write = 1'b0; fb.if_read = 1'b0;
   endtask

   task automatic st_a(input string tag, input int num, input logic en, input logic fn);
      chk({tag, ".num"},     32'(fa.if_num_data_valid), 32'(num));
      chk({tag, ".empty_n"}, 32'(fa.if_empty_n),        32'(en));
      chk({tag, ".full_n"},  32'(fa.if_full_n),         32'(fn));
   endtask

   task automatic st_b(input string tag, input int num, input logic en, input logic fn);
      chk({tag, ".num"},     32'(fb.if_num_data_valid), 32'(num));
      chk({tag, ".empty_n"}, 32'(fb.if_empty_n),        32'(en));
      chk({tag, ".full_n"},  32'(fb.if_full_n),         32'(fn));
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      fa.if_write = 0; fa.if_din = 0; fa.if_read = 0; fa.if_write_ce = 1; fa.if_read_ce = 1;
      fb.if_write = 0; fb.if_din = 0; fb.if_read = 0; fb.if_write_ce = 1; fb.if_read_ce = 1;
      repeat (2) @(posedge clk);
      #1; rst_a_n = 1'b1; rst_b_n = 1'b1;
      st_a("rst_init", 0, 0, 1);

      // Asynchronous reset mid-cycle clears a non-empty FIFO without a clk edge
      op_a(1, 8'h77, 0);
      st_a("pre_rst", 1, 1, 1);
      #2 rst_a_n = 1'b0;
      #1 st_a("async_rst", 0, 0, 1);
      repeat (5) @(posedge clk);
      #1 st_a("rst_hold", 0, 0, 1);
      rst_a_n = 1'b1;

      // Fill
      op_a(1, 8'hA1, 0);
      st_a("push1", 1, 1, 1);
      chk("push1.dout", 32'(fa.if_dout), 32'h A1);
      op_a(1, 8'hB2, 0);
      st_a("push2", 2, 1, 0);
      chk("push2.dout", 32'(fa.if_dout), 32'h A1);

      // Overflow dropped
      op_a(1, 8'hC3, 0);
      st_a("ovf", 2, 1, 0);
      chk("ovf.dout", 32'(fa.if_dout), 32'h A1);

      // Drain
      op_a(0, 8'h00, 1);
      st_a("pop1", 1, 1, 1);
      chk("pop1.dout", 32'(fa.if_dout), 32'h B2);
      op_a(0, 8'h00, 1);
      st_a("pop2", 0, 0, 1);

      // Underflow dropped; next push must land at the head (pointer back at -1)
      op_a(0, 8'h00, 1);
      st_a("udf", 0, 0, 1);
      op_a(1, 8'h11, 1);            // pop blocked while empty: push only
      st_a("push_pop_empty", 1, 1, 1);
      chk("push_pop_empty.dout", 32'(fa.if_dout), 32'h11);

      // Simultaneous at num=1
      op_a(1, 8'h22, 1);
      st_a("pp_one", 1, 1, 1);
      chk("pp_one.dout", 32'(fa.if_dout), 32'h22);

      // Simultaneous at full: pop only
      op_a(1, 8'h33, 0);
      st_a("fill_33", 2, 1, 0);
      op_a(1, 8'h44, 1);
      st_a("pp_full", 1, 1, 1);
      chk("pp_full.dout", 32'(fa.if_dout), 32'h33);

      // ce gating
      repeat (3) op_a(1, 8'h55, 0, 1'b0, 1'b1);
      st_a("wce_off", 1, 1, 1);
      chk("wce_off.dout", 32'(fa.if_dout), 32'h33);
      op_a(0, 8'h00, 1, 1'b1, 1'b0);
      st_a("rce_off", 1, 1, 1);
      chk("rce_off.dout", 32'(fa.if_dout), 32'h33);
      op_a(0, 8'h00, 1);
      st_a("drain_end", 0, 0, 1);

      // Instance B: mid-stream reset with 3 tokens queued
      op_b(1, 8'h01, 0);
      op_b(1, 8'h02, 0);
      op_b(1, 8'h03, 0);
      st_b("b_fill3", 3, 1, 1);
      chk("b_fill3.dout", 32'(fb.if_dout), 32'h01);
      rst_b_n = 1'b0;
      #1 st_b("b_rst", 0, 0, 1);
      @(posedge clk); #1 rst_b_n = 1'b1;
      op_b(1, 8'h5A, 0);
      st_b("b_after_rst", 1, 1, 1);
      chk("b_after_rst.dout", 32'(fb.if_dout), 32'h5A);
      op_b(1, 8'h6B, 0);
      op_b(1, 8'h7C, 0);
      op_b(1, 8'h8D, 0);
      st_b("b_full", 4, 1, 0);
      chk("b_full.dout", 32'(fb.if_dout), 32'h5A);
      op_b(0, 8'h00, 1);
      chk("b_pop1.dout", 32'(fb.if_dout), 32'h6B);
      op_b(0, 8'h00, 1);
      chk("b_pop2.dout", 32'(fb.if_dout), 32'h7C);
      op_b(0, 8'h00, 1);
      chk("b_pop3.dout", 32'(fb.if_dout), 32'h8D);
      op_b(0, 8'h00, 1);
      st_b("b_empty", 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
